msx_io_bridge: RTL and testbench
================================

MSX_IO_BRIDGE -- requirements
Module: msx_io_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 128, number of bus cycles before an unanswered access is aborted; legal range 4..255.
REQ-002 clk  input  1  system clock, 42.95454 MHz domain.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 slot_iorq_n  input  1  cartridge-slot I/O request, asynchronous to clk.
REQ-005 slot_rd_n  input  1  cartridge-slot read strobe, asynchronous to clk.
REQ-006 slot_wr_n  input  1  cartridge-slot write strobe, asynchronous to clk.
REQ-007 slot_a  input  8  slot address A[7:0].
REQ-008 slot_d_in  input  8  slot data bus, sampled on writes.
REQ-009 slot_d_out  output  8  read data driven to the slot.
REQ-010 slot_d_oe  output  1  slot data output enable.
REQ-011 slot_wait_n  output  1  slot WAIT request, active-low.
REQ-012 bus_ioreq  output  1  internal bus I/O-space qualifier.
REQ-013 bus_address  output  8  internal bus address.
REQ-014 bus_write  output  1  1 = write, 0 = read.
REQ-015 bus_valid  output  1  request valid.
REQ-016 bus_ready  input  1  responder accepts the request.
REQ-017 bus_wdata  output  8  write data.
REQ-018 bus_rdata  input  8  read data.
REQ-019 bus_rdata_en  input  1  bus_rdata is valid this cycle.

Function
REQ-020 Strobes, slot_a and slot_d_in SHALL pass through a 2-FF synchronizer; start = synced slot_iorq_n low AND (synced slot_rd_n low OR synced slot_wr_n low), qualified by a rising-edge detect on that condition.
REQ-021 FSM states are IDLE, ACCESS, RDWAIT and HOLD; start in IDLE moves to ACCESS and latches the synced address, data and direction; when rd and wr are both low, write wins.
REQ-022 bus_ioreq and bus_valid SHALL be 1 from the cycle after start, with address, wdata and write held stable, until the cycle in which bus_ready=1 (inclusive); both are 0 on the following cycle.
REQ-023 On write, the ready cycle moves the FSM ACCESS->HOLD; on read it moves to RDWAIT, or directly to HOLD if bus_rdata_en=1 in the same cycle.
REQ-024 The first bus_rdata_en=1 during ACCESS or RDWAIT SHALL capture bus_rdata into slot_d_out and set slot_d_oe=1 on the next cycle; later rdata_en pulses are ignored.
REQ-025 A 8-bit timeout counter clears on start and increments each cycle in ACCESS or RDWAIT; reaching TIMEOUT_CYCLES-1 SHALL drop bus_valid and bus_ioreq, go to HOLD, and leave slot_d_oe=0 and slot_d_out=8'hFF.
REQ-026 HOLD persists while the synced strobe condition is true; when it is false, slot_d_oe->0, slot_d_out->8'hFF and the FSM returns to IDLE.
REQ-027 If the strobe is released before completion, the bus transaction SHALL still run to ready or timeout; slot_d_oe stays 0 and HOLD exits the next cycle.
REQ-028 At most one bus transaction is outstanding; a start outside IDLE is ignored.
REQ-029 bus_address, bus_wdata and bus_write SHALL be 0 whenever bus_valid=0.

Reset
REQ-030 reset_n=0 SHALL immediately force IDLE, counter=0, bus_ioreq/bus_valid/bus_write=0, bus_address/bus_wdata=0, slot_d_oe=0, slot_d_out=8'hFF and slot_wait_n=1, including mid-transaction.
REQ-031 After reset release, a strobe that is already asserted SHALL NOT start a transaction; an edge is required.

Configuration
REQ-032 With MSX_IO_BRIDGE_WAIT_EN defined, slot_wait_n SHALL be 0 from the cycle after start until the cycle the FSM enters HOLD. Without the macro, slot_wait_n is constant 1 and no wait logic is synthesized.

Verification
REQ-033 Write to port B1 with data 8'h5A, responder ready after 3 cycles -> one valid burst of 4 cycles with address=8'hB1, write=1, wdata=8'h5A; FSM reaches HOLD, then IDLE when the strobe rises.
REQ-034 Read of B3 with ready and rdata_en=1 in the same cycle and rdata=8'h0A -> slot_d_out=8'h0A and slot_d_oe=1 until slot_rd_n rises, then 8'hFF and oe=0.
REQ-035 Read of port 8'h40 with no responder -> bus_valid drops after 128 cycles, slot_d_oe never asserts, slot_d_out=8'hFF.
REQ-036 Read with ready at cycle 2 and rdata_en at cycle 5 -> RDWAIT is entered, data captured at cycle 5, and a second rdata_en pulse is ignored.
REQ-037 reset_n pulsed low mid-ACCESS -> all outputs at reset values asynchronously; a held strobe after release starts no transaction.
REQ-038 With MSX_IO_BRIDGE_WAIT_EN, slot_wait_n is low exactly from start+1 to HOLD entry; without the macro it stays 1 throughout.

Source files
------------

// File: rtl/msx_io_bridge.sv
// ---------------------------------------------------------------------------
// msx_io_bridge
//
// Purpose:
//   Bridges MSX cartridge-slot I/O cycles (IORQ/RD/WR strobes, asynchronous to
//   clk) onto a simple internal valid/ready bus. Each slot I/O cycle produces
//   exactly one bus transaction. Read data is returned to the slot through
//   slot_d_out/slot_d_oe until the slot strobe is released. An unanswered
//   access is aborted after TIMEOUT_CYCLES bus cycles.
//
// Ports:
//   clk, reset_n          - system clock, asynchronous active-low reset
//   slot_iorq_n/rd_n/wr_n - slot strobes (asynchronous, synchronised here)
//   slot_a, slot_d_in     - slot address and write data (synchronised here)
//   slot_d_out, slot_d_oe - read data returned to the slot and its enable
//   slot_wait_n           - slot WAIT request, active-low
//   bus_ioreq, bus_valid  - internal bus request qualifiers
//   bus_address, bus_write, bus_wdata - request payload (0 while idle)
//   bus_ready             - responder accepts the request
//   bus_rdata, bus_rdata_en - read data and its qualifier
//
// Parameters:
//   TIMEOUT_CYCLES        - bus cycles before an unanswered access is aborted
//                           (legal range 4..255)
//
// Configuration macro:
//   MSX_IO_BRIDGE_WAIT_EN - when defined, slot_wait_n is held low while a bus
//                           transaction is in flight; otherwise it is tied 1.
// ---------------------------------------------------------------------------
module msx_io_bridge #(
   parameter int TIMEOUT_CYCLES = 128
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       slot_iorq_n,
   input  logic       slot_rd_n,
   input  logic       slot_wr_n,
   input  logic [7:0] slot_a,
   input  logic [7:0] slot_d_in,
   output logic [7:0] slot_d_out,
   output logic       slot_d_oe,
   output logic       slot_wait_n,
   output logic       bus_ioreq,
   output logic [7:0] bus_address,
   output logic       bus_write,
   output logic       bus_valid,
   input  logic       bus_ready,
   input  logic [7:0] bus_rdata,
   input  logic       bus_rdata_en,
   output logic [7:0] bus_wdata
);

   localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

   // Bit 1 of the encoding marks the two "bus busy" states so the WAIT
   // output can come straight from a single state flop.
   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      HOLD   = 2'b01,
      ACCESS = 2'b10,
      RDWAIT = 2'b11
   } BridgeState;

   BridgeState state;

   logic [1:0] iorqSync;
   logic [1:0] rdSync;
   logic [1:0] wrSync;
   logic [7:0] addrMeta;
   logic [7:0] addrSync;
   logic [7:0] dataMeta;
   logic [7:0] dataSync;
   logic       strobePrev;

   logic [7:0] timeoutCount;
   logic       accessWrite;
   logic       readCaptured;
   logic       strobeLost;

   logic       strobeActive;
   logic       startPulse;
   logic       busy;
   logic       captureNow;
   logic       outputAllowed;
   logic       timeoutHit;

   // Two-flop synchronisers for every slot input plus the edge-detect history.
   // The strobe synchronisers and strobePrev reset to the "asserted" state so
   // that a strobe already held low when reset is released looks like a
   // continuing cycle rather than a new edge; a transaction then needs the
   // strobe to be released and asserted again.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         iorqSync   <= 2'b00;
         rdSync     <= 2'b00;
         wrSync     <= 2'b00;
         addrMeta   <= '0;
         addrSync   <= '0;
         dataMeta   <= '0;
         dataSync   <= '0;
         strobePrev <= 1'b1;
      end else begin
         iorqSync   <= {iorqSync[0], slot_iorq_n};
         rdSync     <= {rdSync[0], slot_rd_n};
         wrSync     <= {wrSync[0], slot_wr_n};
         addrMeta   <= slot_a;
         addrSync   <= addrMeta;
         dataMeta   <= slot_d_in;
         dataSync   <= dataMeta;
         strobePrev <= strobeActive;
      end
   end

   // Decode of the synchronised strobes and the per-cycle qualifiers used by
   // the FSM. Read data is only driven back to the slot if the strobe has been
   // held continuously since the access started.
   always_comb begin
      strobeActive  = ~iorqSync[1] & (~rdSync[1] | ~wrSync[1]);
      startPulse    = strobeActive & ~strobePrev;
      busy          = (state == ACCESS) || (state == RDWAIT);
      captureNow    = busy & ~accessWrite & bus_rdata_en & ~readCaptured;
      outputAllowed = strobeActive & ~strobeLost;
      timeoutHit    = (timeoutCount == LAST_COUNT);
   end

   // Main bridge FSM. A new slot edge in IDLE latches the request and raises
   // the bus request; the request drops (and its payload returns to zero) in
   // the cycle after ready or on timeout. Only the first rdata_en of an access
   // is captured. A timeout discards any captured data. HOLD waits for the
   // slot to release its strobe before accepting the next access, so starts
   // seen outside IDLE are simply ignored.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         timeoutCount <= '0;
         accessWrite  <= 1'b0;
         readCaptured <= 1'b0;
         strobeLost   <= 1'b0;
         bus_ioreq    <= 1'b0;
         bus_valid    <= 1'b0;
         bus_write    <= 1'b0;
         bus_address  <= '0;
         bus_wdata    <= '0;
         slot_d_oe    <= 1'b0;
         slot_d_out   <= 8'hFF;
      end else begin
         if (captureNow) begin
            readCaptured <= 1'b1;
            if (outputAllowed) begin
               slot_d_out <= bus_rdata;
               slot_d_oe  <= 1'b1;
            end
         end
         if (busy && !strobeActive) begin
            strobeLost <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (startPulse) begin
                  state        <= ACCESS;
                  timeoutCount <= '0;
                  accessWrite  <= ~wrSync[1];
                  readCaptured <= 1'b0;
                  strobeLost   <= 1'b0;
                  bus_ioreq    <= 1'b1;
                  bus_valid    <= 1'b1;
                  bus_write    <= ~wrSync[1];
                  bus_address  <= addrSync;
                  bus_wdata    <= dataSync;
               end
            end
            ACCESS: begin
               if (bus_ready || timeoutHit) begin
                  bus_ioreq   <= 1'b0;
                  bus_valid   <= 1'b0;
                  bus_write   <= 1'b0;
                  bus_address <= '0;
                  bus_wdata   <= '0;
               end
               if (bus_ready) begin
                  if (accessWrite || bus_rdata_en || readCaptured) begin
                     state <= HOLD;
                  end else begin
                     state <= RDWAIT;
                  end
               end else if (timeoutHit) begin
                  state      <= HOLD;
                  slot_d_oe  <= 1'b0;
                  slot_d_out <= 8'hFF;
               end else begin
                  timeoutCount <= timeoutCount + 8'd1;
               end
            end
            RDWAIT: begin
               if (bus_rdata_en) begin
                  state <= HOLD;
               end else if (timeoutHit) begin
                  state      <= HOLD;
                  slot_d_oe  <= 1'b0;
                  slot_d_out <= 8'hFF;
               end else begin
                  timeoutCount <= timeoutCount + 8'd1;
               end
            end
            HOLD: begin
               if (!strobeActive) begin
                  state      <= IDLE;
                  slot_d_oe  <= 1'b0;
                  slot_d_out <= 8'hFF;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // WAIT is asserted exactly while the FSM sits in ACCESS or RDWAIT, which is
   // the cycle after start up to (not including) the first HOLD cycle.
`ifdef MSX_IO_BRIDGE_WAIT_EN
   assign slot_wait_n = ~state[1];
`else
   assign slot_wait_n = 1'b1;
`endif

endmodule

// File: tb/tb_msx_io_bridge.sv
// ---------------------------------------------------------------------------
// tb_msx_io_bridge
//
// Directed self-checking bench for msx_io_bridge: write burst, read with
// same-cycle data, timeout, split ready/data read, early strobe release,
// asynchronous reset mid-access and recovery afterwards.
// Honours MSX_IO_BRIDGE_WAIT_EN for the expected slot_wait_n level.
// ---------------------------------------------------------------------------
module tb_msx_io_bridge;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       slot_iorq_n;
   logic       slot_rd_n;
   logic       slot_wr_n;
   logic [7:0] slot_a;
   logic [7:0] slot_d_in;
   logic [7:0] slot_d_out;
   logic       slot_d_oe;
   logic       slot_wait_n;
   logic       bus_ioreq;
   logic [7:0] bus_address;
   logic       bus_write;
   logic       bus_valid;
   logic       bus_ready;
   logic [7:0] bus_rdata;
   logic       bus_rdata_en;
   logic [7:0] bus_wdata;

   int checks   = 0;
   int failures = 0;
   int nCycles;
   int validSeen;

`ifdef MSX_IO_BRIDGE_WAIT_EN
   localparam logic WAIT_BUSY = 1'b0;
`else
   localparam logic WAIT_BUSY = 1'b1;
`endif

   msx_io_bridge #(.TIMEOUT_CYCLES(128)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .slot_iorq_n  (slot_iorq_n),
      .slot_rd_n    (slot_rd_n),
      .slot_wr_n    (slot_wr_n),
      .slot_a       (slot_a),
      .slot_d_in    (slot_d_in),
      .slot_d_out   (slot_d_out),
      .slot_d_oe    (slot_d_oe),
      .slot_wait_n  (slot_wait_n),
      .bus_ioreq    (bus_ioreq),
      .bus_address  (bus_address),
      .bus_write    (bus_write),
      .bus_valid    (bus_valid),
      .bus_ready    (bus_ready),
      .bus_rdata    (bus_rdata),
      .bus_rdata_en (bus_rdata_en),
      .bus_wdata    (bus_wdata)
   );

   // Free-running 100 MHz-style clock; outputs are sampled on the falling edge.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drives all slot-side inputs at once.
   task automatic applyStimulus(input logic iorqN, input logic rdN, input logic wrN,
                                input logic [7:0] addr, input logic [7:0] data);
      slot_iorq_n = iorqN;
      slot_rd_n   = rdN;
      slot_wr_n   = wrN;
      slot_a      = addr;
      slot_d_in   = data;
   endtask

   // Confirms the internal bus is idle with a zeroed payload.
   task automatic checkIdleBus(input string tag);
      checkOutput({tag, " valid"},  bus_valid,   32'd0);
      checkOutput({tag, " ioreq"},  bus_ioreq,   32'd0);
      checkOutput({tag, " write"},  bus_write,   32'd0);
      checkOutput({tag, " addr"},   bus_address, 32'd0);
      checkOutput({tag, " wdata"},  bus_wdata,   32'd0);
   endtask

   // Waits (bounded) for bus_valid and checks the start latency in cycles.
   task automatic waitForValid(input string tag, input int expectLatency);
      int n = 0;
      while (!bus_valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      checkOutput({tag, " latency"}, n, expectLatency);
   endtask

   // Plays the responder for one request starting at its first valid cycle.
   // readyAt/rdEnAt are 1-based valid-cycle numbers (0 = never). Returns the
   // number of cycles bus_valid stayed high.
   task automatic runBurst(input string tag, input int readyAt, input int rdEnAt,
                           input logic [7:0] rdata, input logic [7:0] expAddr,
                           input logic expWrite, input logic [7:0] expWdata,
                           output int cycles);
      cycles = 0;
      for (int guard = 0; guard < 300; guard++) begin
         if (!bus_valid) break;
         cycles++;
         checkOutput({tag, " addr"},  bus_address, expAddr);
         checkOutput({tag, " write"}, bus_write,   expWrite);
         checkOutput({tag, " ioreq"}, bus_ioreq,   32'd1);
         checkOutput({tag, " wait"},  slot_wait_n, WAIT_BUSY);
         if (expWrite) checkOutput({tag, " wdata"}, bus_wdata, expWdata);
         bus_ready    = (cycles == readyAt);
         bus_rdata_en = (cycles == rdEnAt);
         bus_rdata    = rdata;
         @(negedge clk);
         bus_ready    = 1'b0;
         bus_rdata_en = 1'b0;
      end
   endtask

   // Hard stop in case anything stalls the directed sequence.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence of bridge scenarios.
   initial begin
      reset_n      = 1'b0;
      bus_ready    = 1'b0;
      bus_rdata    = 8'h00;
      bus_rdata_en = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 8'h00);

      repeat (3) @(negedge clk);
      checkIdleBus("reset");
      checkOutput("reset d_oe",  slot_d_oe,   32'd0);
      checkOutput("reset d_out", slot_d_out,  32'hFF);
      checkOutput("reset wait",  slot_wait_n, 32'd1);
      reset_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] write B1 <- 5A, ready after 3 cycles");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'hB1, 8'h5A);
      waitForValid("wr", 3);
      runBurst("wr", 4, 0, 8'h00, 8'hB1, 1'b1, 8'h5A, nCycles);
      checkOutput("wr burst len", nCycles, 32'd4);
      checkIdleBus("wr after");
      checkOutput("wr hold wait", slot_wait_n, 32'd1);
      checkOutput("wr d_oe",      slot_d_oe,   32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hB1, 8'h5A);
      repeat (5) @(negedge clk);

      $display("[TB] read B3, ready and data together");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'hB3, 8'h00);
      waitForValid("rd0", 3);
      runBurst("rd0", 1, 1, 8'h0A, 8'hB3, 1'b0, 8'h00, nCycles);
      checkOutput("rd0 burst len", nCycles,    32'd1);
      checkIdleBus("rd0 after");
      checkOutput("rd0 d_oe",      slot_d_oe,  32'd1);
      checkOutput("rd0 d_out",     slot_d_out, 32'h0A);
      @(negedge clk);
      checkOutput("rd0 d_out held", slot_d_out, 32'h0A);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hB3, 8'h00);
      repeat (2) @(negedge clk);
      checkOutput("rd0 oe until sync", slot_d_oe, 32'd1);
      @(negedge clk);
      checkOutput("rd0 oe released",   slot_d_oe,  32'd0);
      checkOutput("rd0 d_out released", slot_d_out, 32'hFF);
      repeat (4) @(negedge clk);

      $display("[TB] read 40 with no responder");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h40, 8'h00);
      waitForValid("tmo", 3);
      runBurst("tmo", 0, 0, 8'h00, 8'h40, 1'b0, 8'h00, nCycles);
      checkOutput("tmo burst len", nCycles, 32'd128);
      checkIdleBus("tmo after");
      checkOutput("tmo d_oe",  slot_d_oe,  32'd0);
      checkOutput("tmo d_out", slot_d_out, 32'hFF);
      @(negedge clk);
      checkOutput("tmo d_oe hold", slot_d_oe, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h40, 8'h00);
      repeat (5) @(negedge clk);

      $display("[TB] read 7C, ready at 2, data at 5, extra data at 7");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h7C, 8'h00);
      waitForValid("rdw", 3);
      @(negedge clk);
      checkOutput("rdw valid c2", bus_valid, 32'd1);
      bus_ready = 1'b1;
      @(negedge clk);
      bus_ready = 1'b0;
      checkIdleBus("rdw c3");
      checkOutput("rdw c3 d_oe", slot_d_oe,   32'd0);
      checkOutput("rdw c3 wait", slot_wait_n, WAIT_BUSY);
      @(negedge clk);
      @(negedge clk);
      bus_rdata    = 8'h3C;
      bus_rdata_en = 1'b1;
      @(negedge clk);
      bus_rdata_en = 1'b0;
      checkOutput("rdw d_oe",  slot_d_oe,   32'd1);
      checkOutput("rdw d_out", slot_d_out,  32'h3C);
      checkOutput("rdw wait",  slot_wait_n, 32'd1);
      @(negedge clk);
      bus_rdata    = 8'h99;
      bus_rdata_en = 1'b1;
      @(negedge clk);
      bus_rdata_en = 1'b0;
      checkOutput("rdw second ignored", slot_d_out, 32'h3C);
      checkOutput("rdw second oe",      slot_d_oe,  32'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h7C, 8'h00);
      repeat (5) @(negedge clk);
      checkOutput("rdw released d_out", slot_d_out, 32'hFF);

      $display("[TB] read 55 with strobe released before completion");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h55, 8'h00);
      waitForValid("rel", 3);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h55, 8'h00);
      runBurst("rel", 5, 5, 8'hC3, 8'h55, 1'b0, 8'h00, nCycles);
      checkOutput("rel burst len", nCycles,    32'd5);
      checkOutput("rel d_oe",      slot_d_oe,  32'd0);
      checkOutput("rel d_out",     slot_d_out, 32'hFF);
      @(negedge clk);
      checkOutput("rel d_oe later", slot_d_oe, 32'd0);
      repeat (4) @(negedge clk);

      $display("[TB] reset pulse during access to 20");
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h20, 8'h00);
      waitForValid("rst", 3);
      #2;
      reset_n = 1'b0;
      #1;
      checkIdleBus("rst async");
      checkOutput("rst d_oe",  slot_d_oe,   32'd0);
      checkOutput("rst d_out", slot_d_out,  32'hFF);
      checkOutput("rst wait",  slot_wait_n, 32'd1);
      @(negedge clk);
      reset_n   = 1'b1;
      validSeen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus_valid) validSeen++;
      end
      checkOutput("rst held strobe no start", validSeen, 32'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 8'h00);
      repeat (5) @(negedge clk);

      $display("[TB] write 10 <- 7E after reset");
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 8'h7E);
      waitForValid("wr2", 3);
      runBurst("wr2", 1, 0, 8'h00, 8'h10, 1'b1, 8'h7E, nCycles);
      checkOutput("wr2 burst len", nCycles, 32'd1);
      checkIdleBus("wr2 after");
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 8'h7E);
      repeat (5) @(negedge clk);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
